// File: rtl/kpn_fixed_pkg.sv
// kpn_fixed_pkg
// Shared fixed-point definitions for the KPN processing nodes.
// Tokens are signed Q(BITS_NUMBER-FRAC_BITS).FRAC_BITS. The round-and-saturate
// helper turns a full-width signed product back into a token. It rounds half up
// and clamps to the token range.
package kpn_fixed_pkg;

  localparam int BITS_NUMBER = 16;
  localparam int FRAC_BITS   = 8;
  localparam int PROD_BITS   = 2 * BITS_NUMBER;

  localparam logic [BITS_NUMBER-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [BITS_NUMBER-1:0] SAT_MIN = 16'h8000;

  // 2**(FRAC_BITS-1) in the one-bit-wider product domain, so the bias can never wrap.
  localparam logic signed [PROD_BITS:0] ROUND_HALF =
    {{(PROD_BITS - FRAC_BITS + 1){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

  // Round half up, drop the fractional bits with an arithmetic shift, then clamp.
  function automatic logic [BITS_NUMBER-1:0] round_sat(
    input logic signed [PROD_BITS-1:0] product
  );
    logic signed [PROD_BITS:0] biased;
    logic signed [PROD_BITS:0] shifted;
    logic [BITS_NUMBER-1:0]    result;
    biased  = {product[PROD_BITS-1], product} + ROUND_HALF;
    shifted = biased >>> FRAC_BITS;
    // The value fits only if every bit above the token sign bit equals that sign bit.
    if ((&shifted[PROD_BITS:BITS_NUMBER-1]) || !(|shifted[PROD_BITS:BITS_NUMBER-1])) begin
      result = shifted[BITS_NUMBER-1:0];
    end else if (shifted[PROD_BITS]) begin
      result = SAT_MIN;
    end else begin
      result = SAT_MAX;
    end
    return result;
  endfunction

endpackage

// File: rtl/kpn_token_buffer.sv
// kpn_token_buffer
// Synchronous FIFO with 2**DEPTH_LOG2 entries. It has push/pop strobes, exposes
// the head word combinationally, and uses a synchronous active-high reset.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_data     write request and data
//   pop                 remove the head entry
//   head_data           current head entry (valid when !empty)
//   full, empty         status derived from an occupancy count
module kpn_token_buffer #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_EMPTY = {(DEPTH_LOG2 + 1){1'b0}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // Status and guarded strobes. A push into a full buffer is legal only alongside a pop.
  always_comb begin
    full      = (count == CNT_FULL);
    empty     = (count == CNT_EMPTY);
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    head_data = mem[rd_ptr];
  end

  // Storage array. It needs no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH, and the count tracks the occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {DEPTH_LOG2{1'b0}};
      rd_ptr <= {DEPTH_LOG2{1'b0}};
      count  <= CNT_EMPTY;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kpn_scale_process.sv
// kpn_scale_process
// KPN node that scales each incoming fixed-point token by COEFF, with rounding
// and saturation. The input side cannot be stalled. A small token buffer
// absorbs downstream stalls, and tokens arriving while it is full are dropped
// and flagged.
// Pipeline: buffer -> S1 (full-width product) -> S2 (out_data/out_wr).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   in_data, in_wr incoming token and its write strobe
//   out_full       downstream full; blocks the output write
//   out_data       scaled token, held with out_wr until accepted
//   out_wr         output write request
//   overflow       sticky flag, set when an input token was dropped
//   token_count    number of accepted output tokens (wraps)
// BITS_NUMBER/FRAC_BITS must match kpn_fixed_pkg, because round_sat is sized from it.
module kpn_scale_process
  import kpn_fixed_pkg::*;
#(
  parameter int                     BITS_NUMBER  = 16,
  parameter int                     FRAC_BITS    = 8,
  parameter logic [BITS_NUMBER-1:0] COEFF        = 16'h0200,
  parameter int                     BUF_ELEMENTS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BITS_NUMBER-1:0] in_data,
  input  logic                   in_wr,
  input  logic                   out_full,
  output logic [BITS_NUMBER-1:0] out_data,
  output logic                   out_wr,
  output logic                   overflow,
  output logic [15:0]            token_count
);

  localparam logic signed [BITS_NUMBER-1:0] COEFF_S = COEFF;

  logic [BITS_NUMBER-1:0]          head;
  logic                            buf_full;
  logic                            buf_empty;
  logic                            push;
  logic                            pop;
  logic                            s2_ready;
  logic                            s1_valid;
  logic signed [2*BITS_NUMBER-1:0] s1_product;

  kpn_token_buffer #(
    .WIDTH      (BITS_NUMBER),
    .DEPTH_LOG2 (BUF_ELEMENTS)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Handshake: S2 can take a new token when it is empty or its token leaves this edge.
  // S1 then advances with S2, so the buffer may pop into an empty or advancing S1.
  always_comb begin
    s2_ready = !out_wr || !out_full;
    pop      = !buf_empty && (!s1_valid || s2_ready);
    push     = in_wr && (!buf_full || pop);
  end

  // Pipeline stages, output handshake, drop flag and acceptance counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_product  <= {(2*BITS_NUMBER){1'b0}};
      out_data    <= {BITS_NUMBER{1'b0}};
      out_wr      <= 1'b0;
      overflow    <= 1'b0;
      token_count <= 16'd0;
    end else begin
      if (in_wr && !push) begin
        overflow <= 1'b1;
      end

      if (pop) begin
        s1_product <= $signed(head) * COEFF_S;
        s1_valid   <= 1'b1;
      end else if (s2_ready) begin
        s1_valid   <= 1'b0;
      end else begin
        s1_valid   <= s1_valid;
      end

      // When S1 is empty, out_data keeps its last value and only out_wr drops.
      if (s2_ready) begin
        if (s1_valid) begin
          out_data <= round_sat(s1_product);
          out_wr   <= 1'b1;
        end else begin
          out_wr   <= 1'b0;
        end
      end

      if (out_wr && !out_full) begin
        token_count <= token_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_kpn_scale_process.sv
// Testbench for kpn_scale_process. Two instances share the stimulus: dut
// (COEFF 2.0) and dut_r (COEFF 0.5). Expected tokens come from an arithmetic
// reference model and are queued per instance. A negedge monitor checks every
// accepted output against the head of its queue.
module tb_kpn_scale_process;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_wr;
  logic        out_full;
  logic [15:0] in_data;
  logic [15:0] out_data, r_out_data;
  logic        out_wr, r_out_wr;
  logic        overflow, r_overflow;
  logic [15:0] token_count, r_token_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          accepts  = 0;
  int          cyc      = 0;
  int          acc_cyc[$];
  logic [15:0] q[$];
  logic [15:0] q2[$];
  logic [15:0] exp_count;

  kpn_scale_process dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_wr(in_wr), .out_full(out_full),
    .out_data(out_data), .out_wr(out_wr), .overflow(overflow), .token_count(token_count)
  );

  kpn_scale_process #(.COEFF(16'h0080)) dut_r (
    .clk(clk), .reset(reset), .in_data(in_data), .in_wr(in_wr), .out_full(out_full),
    .out_data(r_out_data), .out_wr(r_out_wr), .overflow(r_overflow), .token_count(r_token_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued product in units of 2**-16. Round half up to units
  // of 2**-8 by flooring (p + 128) / 256, then clamp to the signed 16-bit range.
  function automatic logic [15:0] model(input logic [15:0] v, input logic [15:0] c);
    longint a, b, p, r;
    a = longint'($signed(v));
    b = longint'($signed(c));
    p = a * b + 64'sd128;
    r = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  // Output monitor. A token is accepted at the next edge when out_wr=1 and out_full=0.
  always @(negedge clk) begin
    if (!reset && out_wr && !out_full) begin
      chk("sb_pending", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) chk("sb_data", {16'd0, out_data}, {16'd0, q.pop_front()});
      accepts++;
      acc_cyc.push_back(cyc);
    end
    if (!reset && r_out_wr && !out_full) begin
      chk("sb_r_pending", {31'd0, q2.size() != 0}, 32'd1);
      if (q2.size() != 0) chk("sb_r_data", {16'd0, r_out_data}, {16'd0, q2.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one token for one edge; optionally record it as an expected output.
  task automatic send(input logic [15:0] v, input bit enq);
    in_data = v;
    in_wr   = 1'b1;
    if (enq) begin
      q.push_back(model(v, 16'h0200));
      q2.push_back(model(v, 16'h0080));
      exp_count = exp_count + 16'd1;
    end
    step();
    in_wr = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && (q.size() != 0 || q2.size() != 0); i++) step();
    chk(tag, q.size() + q2.size(), 32'd0);
  endtask

  initial begin
    int          acc0;
    int          full_left;
    bit          started;
    logic [15:0] v;
    logic [15:0] vals[12];

    reset = 1'b1; in_wr = 1'b0; in_data = 16'h0000; out_full = 1'b0; exp_count = 16'd0;
    step(); step();
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_wr", {31'd0, out_wr}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_token_count", {16'd0, token_count}, 32'd0);
    reset = 1'b0;
    step();

    // Single token: presented after edge N and sampled at N+1; out_wr rises after N+3.
    send(16'h0100, 1'b1);
    chk("lat_n1_wr", {31'd0, out_wr}, 32'd0);
    step();
    chk("lat_n2_wr", {31'd0, out_wr}, 32'd0);
    step();
    chk("lat_n3_wr", {31'd0, out_wr}, 32'd1);
    chk("lat_n3_data", {16'd0, out_data}, 32'h0200);
    step();
    chk("single_count", {16'd0, token_count}, 32'd1);

    // Saturation on both rails, plus zero.
    send(16'h7000, 1'b1); send(16'h9000, 1'b1); send(16'h0000, 1'b1);
    chk("sat_pos", {16'd0, out_data}, 32'h7FFF);
    step();
    chk("sat_neg", {16'd0, out_data}, 32'h8000);
    step();
    chk("sat_zero", {16'd0, out_data}, 32'h0000);
    wait_drain("sat_drain");
    chk("sat_overflow", {31'd0, overflow}, 32'd0);

    // Rounding observed on the COEFF=0.5 instance.
    send(16'h0001, 1'b1); send(16'hFFFF, 1'b1); send(16'h0003, 1'b1);
    chk("rnd_0001", {16'd0, r_out_data}, 32'h0001);
    step();
    chk("rnd_ffff", {16'd0, r_out_data}, 32'h0000);
    step();
    chk("rnd_0003", {16'd0, r_out_data}, 32'h0002);
    wait_drain("rnd_drain");
    chk("rnd_count", {16'd0, token_count}, {16'd0, exp_count});

    // Continuous random stream: one token per cycle in and out.
    acc_cyc.delete();
    for (int k = 0; k < 100; k++) send(16'($urandom), 1'b1);
    wait_drain("stream_drain");
    chk("stream_outputs", acc_cyc.size(), 32'd100);
    if (acc_cyc.size() == 100) chk("stream_span", acc_cyc[99] - acc_cyc[0], 32'd99);
    chk("stream_overflow", {31'd0, overflow}, 32'd0);
    chk("stream_count", {16'd0, token_count}, {16'd0, exp_count});

    // Backpressure: 12 tokens, 15-cycle stall from the first out_wr; only 6 survive.
    for (int k = 0; k < 12; k++) vals[k] = 16'($urandom);
    acc0 = accepts; started = 1'b0; full_left = 0;
    for (int k = 0; k < 52; k++) begin
      if (k < 12) send(vals[k], k < 6);
      else if (started && full_left == 0) break;
      else step();
      if (!started && out_wr) begin
        started = 1'b1; full_left = 15; out_full = 1'b1;
      end else if (started && full_left > 0) begin
        full_left--;
        if (full_left == 0) out_full = 1'b0;
      end
    end
    chk("bp_stall_seen", {31'd0, started}, 32'd1);
    chk("bp_released", {31'd0, out_full}, 32'd0);
    wait_drain("bp_drain");
    chk("bp_outputs", accepts - acc0, 32'd6);
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    chk("bp_count", {16'd0, token_count}, {16'd0, exp_count});

    // Reset mid-operation: S2 and S1 loaded, 3 tokens buffered, output stalled.
    out_full = 1'b1;
    for (int k = 0; k < 5; k++) send(16'($urandom), 1'b0);
    chk("mr_pre_wr", {31'd0, out_wr}, 32'd1);
    reset = 1'b1;
    step();
    chk("mr_out_wr", {31'd0, out_wr}, 32'd0);
    chk("mr_out_data", {16'd0, out_data}, 32'd0);
    chk("mr_overflow", {31'd0, overflow}, 32'd0);
    chk("mr_count", {16'd0, token_count}, 32'd0);
    reset = 1'b0; out_full = 1'b0; exp_count = 16'd0;
    for (int k = 0; k < 8; k++) step();
    chk("mr_idle_wr", {31'd0, out_wr}, 32'd0);
    v = 16'($urandom);
    send(v, 1'b1);
    chk("mr_lat_n1", {31'd0, out_wr}, 32'd0);
    step();
    chk("mr_lat_n2", {31'd0, out_wr}, 32'd0);
    step();
    chk("mr_lat_n3", {31'd0, out_wr}, 32'd1);
    chk("mr_lat_data", {16'd0, out_data}, {16'd0, model(v, 16'h0200)});
    wait_drain("mr_drain");
    chk("mr_final_count", {16'd0, token_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
